ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard on the shared PS2_CLK/PS2_DAT lines.
- Complements the existing PS/2 receive path (kb_driver).
- Drives both lines open-drain through active-high pull-low enables. Reports completion, the device ACK and errors to the memory-mapped CPU side.

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_line_sync.sv | 36 +++
 rtl/ps2_host_tx.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-to-device transmit path.
//   - ps2_state_t      : transmitter FSM state encoding
//   - ERR_*            : err_code values reported to the CPU side
//   - *_CYCLES_50M     : line timing at a 50 MHz CLOCK_50
//   - max3/frame_bits  : elaboration and frame-building helpers
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam int INHIBIT_CYCLES_50M   = 5000;     // 100 us
    localparam int TIMEOUT_CYCLES_50M   = 750000;   // 15 ms
    localparam int IDLE_WAIT_CYCLES_50M = 2500;     // 50 us

    // Extra attempts after the first failure when retries are built in.
    localparam int RETRY_MAX = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits shifted out after the start bit, LSB first: 8 data bits then odd parity.
    function automatic logic [8:0] frame_bits(input logic [7:0] d);
        return {~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer and falling-edge detect for one PS/2 line.
//   CLOCK_50  in  system clock
//   rst       in  synchronous reset, active-high
//   line_in   in  raw (asynchronous) pin level
//   line_sync out synchronized level
//   line_fe   out one-cycle pulse on a synchronized 1 -> 0 transition
// Registers reset to 1 because idle PS/2 lines are pulled high; this keeps a
// reset from manufacturing a spurious edge.
module ps2_line_sync (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic line_fe
);

    logic meta;
    logic cur;
    logic prev;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            meta <= 1'b1;
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line_in;
            cur  <= meta;
            prev <= cur;
        end
    end

    assign line_sync = cur;
    assign line_fe   = prev & ~cur;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to the
// keyboard over the shared open-drain PS2_CLK/PS2_DAT lines.
//   CLOCK_50    in  system clock
//   rst         in  synchronous reset, active-high (releases both lines at once)
//   tx_data     in  command byte, taken when tx_valid && tx_ready
//   tx_valid    in  send request
//   tx_ready    out high only while idle
//   ps2_clk_in  in  raw PS2_CLK level
//   ps2_dat_in  in  raw PS2_DAT level
//   ps2_clk_oe  out 1 = pull PS2_CLK low
//   ps2_dat_oe  out 1 = pull PS2_DAT low
//   busy        out frame in progress (gates the receive path)
//   tx_done     out one-cycle pulse: frame ACKed by the device
//   tx_err      out one-cycle pulse: NACK or timeout
//   err_code    out 0 none, 1 nack, 2 timeout; held until the next accept
// Build option: define PS2_TX_RETRY_EN to re-send a failed byte up to two
// more times before reporting the failure.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES   = INHIBIT_CYCLES_50M,
    parameter int TIMEOUT_CYCLES   = TIMEOUT_CYCLES_50M,
    parameter int IDLE_WAIT_CYCLES = IDLE_WAIT_CYCLES_50M
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    // One counter is shared by the inhibit, timeout and idle-wait phases;
    // they never overlap.
    localparam int CNT_MAX = max3(INHIBIT_CYCLES, TIMEOUT_CYCLES, IDLE_WAIT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_WAIT_CYCLES - 1);

    ps2_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bitcnt;
    logic [8:0]       shreg;

`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_cnt;
    logic [7:0]       data_lat;
`endif

    logic clk_s;
    logic clk_fe;
    logic dat_s;
    logic dat_fe_unused;

    ps2_line_sync u_clk_sync (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_s),
        .line_fe   (clk_fe)
    );

    ps2_line_sync u_dat_sync (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .line_in   (ps2_dat_in),
        .line_sync (dat_s),
        .line_fe   (dat_fe_unused)
    );

    logic timeout_hit;
    logic nack_hit;

    // The timeout covers the whole device-clocked part of the frame and may
    // cut a bit short; it takes precedence over a NACK seen the same cycle.
    always_comb begin
        timeout_hit = 1'b0;
        nack_hit    = 1'b0;
        if ((state == S_SHIFT) || (state == S_ACK))
            timeout_hit = (cnt == TMO_LAST);
        if (state == S_ACK)
            nack_hit = clk_fe & dat_s;
    end

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= S_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            err_code   <= ERR_NONE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt  <= '0;
            data_lat   <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            if (timeout_hit || nack_hit) begin
`ifdef PS2_TX_RETRY_EN
                if (retry_cnt != 2'(RETRY_MAX)) begin
                    // Start the whole frame over, including the inhibit phase.
                    retry_cnt  <= retry_cnt + 1'b1;
                    shreg      <= frame_bits(data_lat);
                    bitcnt     <= '0;
                    cnt        <= '0;
                    ps2_clk_oe <= 1'b1;
                    ps2_dat_oe <= 1'b0;
                    state      <= S_INHIBIT;
                end else
`endif
                begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_err     <= 1'b1;
                    err_code   <= timeout_hit ? ERR_TIMEOUT : ERR_NACK;
                    state      <= S_ERR;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_valid) begin
                            shreg      <= frame_bits(tx_data);
                            bitcnt     <= '0;
                            err_code   <= ERR_NONE;
                            cnt        <= '0;
                            ps2_clk_oe <= 1'b1;
                            ps2_dat_oe <= 1'b0;
                            state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            retry_cnt  <= '0;
                            data_lat   <= tx_data;
`endif
                        end
                    end

                    // Clock held low long enough that the device aborts
                    // anything it was sending; then present the start bit.
                    S_INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            ps2_dat_oe <= 1'b1;
                            cnt        <= '0;
                            state      <= S_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    // Data low for one cycle before clock release forms the
                    // request-to-send condition.
                    S_REQ: begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        state      <= S_SHIFT;
                    end

                    // Each device falling edge moves the next bit onto the
                    // line; the device samples it on the following rising edge.
                    S_SHIFT: begin
                        cnt <= cnt + 1'b1;
                        if (clk_fe) begin
                            if (bitcnt == 4'd9) begin
                                ps2_dat_oe <= 1'b0;   // stop bit
                                state      <= S_ACK;
                            end else begin
                                ps2_dat_oe <= ~shreg[0];
                                shreg      <= {1'b0, shreg[8:1]};
                                bitcnt     <= bitcnt + 1'b1;
                            end
                        end
                    end

                    // Only an ACK (data low) reaches here; a NACK is caught above.
                    S_ACK: begin
                        cnt <= cnt + 1'b1;
                        if (clk_fe) begin
                            cnt   <= '0;
                            state <= S_WAIT_IDLE;
                        end
                    end

                    // Give the device time to release both lines so the
                    // receive path does not see the ACK tail as a new frame.
                    S_WAIT_IDLE: begin
                        if ((clk_s && dat_s) || (cnt == IDLE_LAST)) begin
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_DONE:  state <= S_IDLE;
                    S_ERR:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench for ps2_host_tx with a
// behavioural PS/2 keyboard that clocks frames in and ACKs or NACKs them.
// Timing parameters are scaled down so the whole run stays short.
module tb_ps2_host_tx;

    localparam int INH = 200;
    localparam int TMO = 3000;
    localparam int IW  = 100;
    localparam int H   = 20;     // device half clock period, in system cycles

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, tx_done, tx_err;
    logic [1:0] err_code;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INH),
        .TIMEOUT_CYCLES   (TMO),
        .IDLE_WAIT_CYCLES (IW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Passive monitor: monotonic event counters sampled on the falling edge.
    int cyc = 0, inh_n = 0, done_n = 0, err_n = 0;
    int hi_len = 0, last_hi_len = 0, release_cyc = 0, err_at = 0;
    logic dat_at_release = 1'b0;
    logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;

    always @(negedge CLOCK_50) begin
        cyc = cyc + 1;
        if (ps2_clk_oe && !prev_clk_oe) begin
            inh_n  = inh_n + 1;
            hi_len = 0;
        end
        if (ps2_clk_oe) hi_len = hi_len + 1;
        if (!ps2_clk_oe && prev_clk_oe) begin
            last_hi_len    = hi_len;
            release_cyc    = cyc;
            dat_at_release = prev_dat_oe;
        end
        if (tx_done) done_n = done_n + 1;
        if (tx_err) begin
            err_n  = err_n + 1;
            err_at = cyc;
        end
        prev_clk_oe = ps2_clk_oe;
        prev_dat_oe = ps2_dat_oe;
    end

    // Reference frame as the device should see it: start 0, data LSB first,
    // odd parity (1 when the data has an even number of ones), stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0), d, 1'b0};
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc_wait(1);
        tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for a request-to-send, then generates nfe clocks,
    // reading the line before each rising edge. Drives ack_bit for clock 11.
    task automatic dev_frame(input logic ack_bit, input int nfe,
                             output logic [10:0] got, output bit ok);
        int n;
        ok  = 1'b1;
        got = '1;
        n = 0;
        while (ps2_clk_oe !== 1'b1 && n < 4000) begin cyc_wait(1); n++; end
        if (n >= 4000) begin ok = 1'b0; return; end
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < 4000) begin cyc_wait(1); n++; end
        if (n >= 4000) begin ok = 1'b0; return; end
        got[0] = ps2_dat_in;
        cyc_wait(H / 2);
        for (int i = 1; i <= nfe; i++) begin
            if (i == 11) dev_dat = ack_bit;
            dev_clk = 1'b0;
            cyc_wait(H);
            if (i <= 10) got[i] = ps2_dat_in;
            dev_clk = 1'b1;
            cyc_wait(H);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_outcome(input int bd, input int be, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_n == bd && err_n == be && n < budget) begin cyc_wait(1); n++; end
        ok = (n < budget);
        cyc_wait(5);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        cyc_wait(3);
        @(negedge CLOCK_50);
        obs = {tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_err, err_code};
        n_vec++;
        if (obs !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected %b", obs, 8'b1000_0000);
        end
        rst = 1'b0;
        cyc_wait(2);
    endtask

    // Full ACKed frame; a second request while busy must be ignored.
    task automatic test_frame(input logic [7:0] d, input string name);
        logic [10:0] got, ef;
        bit dok, wok;
        int bd, be, bi;
        bd = done_n; be = err_n; bi = inh_n;
        ef = exp_frame(d);
        fork
            begin
                send_byte(d);
                cyc_wait(50);
                tx_data  = ~d;
                tx_valid = 1'b1;
                cyc_wait(3);
                tx_valid = 1'b0;
            end
            dev_frame(1'b0, 11, got, dok);
        join
        wait_outcome(bd, be, 400, wok);
        n_vec++;
        if (!dok || got !== ef) begin
            n_bad++;
            $display("FAIL %s frame: got %b expected %b (device ok %0d)", name, got, ef, dok);
        end
        n_vec++;
        if (!wok || (done_n - bd) !== 1 || (err_n - be) !== 0) begin
            n_bad++;
            $display("FAIL %s done_pulse: done %0d err %0d expected 1 0", name, done_n - bd, err_n - be);
        end
        n_vec++;
        if (err_code !== 2'd0 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s end_state: err_code %0d ready %b expected 0 1", name, err_code, tx_ready);
        end
        n_vec++;
        if ((inh_n - bi) !== 1) begin
            n_bad++;
            $display("FAIL %s inhibit_count: got %0d expected 1", name, inh_n - bi);
        end
        n_vec++;
        if (last_hi_len < INH || dat_at_release !== 1'b1) begin
            n_bad++;
            $display("FAIL %s request: clk_oe held %0d (need >= %0d), dat_oe at release %b expected 1",
                     name, last_hi_len, INH, dat_at_release);
        end
    endtask

`ifndef PS2_TX_RETRY_EN
    task automatic test_nack();
        logic [10:0] got, ef;
        logic [7:0]  d;
        bit dok, wok;
        int bd, be;
        d  = 8'($urandom);
        ef = exp_frame(d);
        bd = done_n; be = err_n;
        fork
            send_byte(d);
            dev_frame(1'b1, 11, got, dok);
        join
        wait_outcome(bd, be, 400, wok);
        n_vec++;
        if (!dok || got !== ef) begin
            n_bad++;
            $display("FAIL nack frame: got %b expected %b", got, ef);
        end
        n_vec++;
        if (!wok || (err_n - be) !== 1 || (done_n - bd) !== 0) begin
            n_bad++;
            $display("FAIL nack pulses: err %0d done %0d expected 1 0", err_n - be, done_n - bd);
        end
        n_vec++;
        if (err_code !== 2'd1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL nack state: err_code %0d clk_oe %b dat_oe %b expected 1 0 0",
                     err_code, ps2_clk_oe, ps2_dat_oe);
        end
    endtask

    task automatic test_timeout();
        bit wok;
        int bd, be;
        bd = done_n; be = err_n;
        send_byte(8'($urandom));
        wait_outcome(bd, be, INH + TMO + 200, wok);
        n_vec++;
        if (!wok || (err_n - be) !== 1 || (done_n - bd) !== 0) begin
            n_bad++;
            $display("FAIL timeout pulses: err %0d done %0d expected 1 0", err_n - be, done_n - bd);
        end
        n_vec++;
        if ((err_at - release_cyc) !== TMO) begin
            n_bad++;
            $display("FAIL timeout latency: got %0d expected %0d", err_at - release_cyc, TMO);
        end
        n_vec++;
        if (err_code !== 2'd2 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout state: err_code %0d clk_oe %b dat_oe %b expected 2 0 0",
                     err_code, ps2_clk_oe, ps2_dat_oe);
        end
    endtask
`endif

    // Reset after the fifth device clock; bit 4 is forced to 0 so the host
    // is actively pulling data low when reset lands.
    task automatic test_reset_mid();
        logic [10:0] got, ef;
        logic [7:0]  d;
        logic [5:0]  g6, e6;
        logic [3:0]  obs;
        bit dok;
        d  = 8'($urandom) & 8'hEF;
        ef = exp_frame(d);
        fork
            send_byte(d);
            dev_frame(1'b0, 5, got, dok);
        join
        g6 = got[5:0];
        e6 = ef[5:0];
        n_vec++;
        if (!dok || g6 !== e6 || ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid pre: bits %b expected %b dat_oe %b busy %b", g6, e6, ps2_dat_oe, busy);
        end
        rst = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        obs = {ps2_clk_oe, ps2_dat_oe, tx_ready, busy};
        n_vec++;
        if (obs !== 4'b0010) begin
            n_bad++;
            $display("FAIL rst_mid release: {clk_oe,dat_oe,ready,busy} %b expected 0010", obs);
        end
        rst = 1'b0;
        cyc_wait(2);
        test_frame(8'hFF, "ff_after_rst");
    endtask

`ifdef PS2_TX_RETRY_EN
    task automatic test_retry();
        logic [10:0] g1, g2, g3, ef;
        logic [7:0]  d;
        bit o1, o2, o3, wok;
        int bd, be, bi;
        d  = 8'($urandom);
        ef = exp_frame(d);
        bd = done_n; be = err_n; bi = inh_n;
        fork
            begin
                send_byte(d);
                cyc_wait(50);
                tx_data  = ~d;
                tx_valid = 1'b1;
                cyc_wait(3);
                tx_valid = 1'b0;
            end
            begin
                dev_frame(1'b1, 11, g1, o1);
                dev_frame(1'b1, 11, g2, o2);
                dev_frame(1'b0, 11, g3, o3);
            end
        join
        wait_outcome(bd, be, 400, wok);
        n_vec++;
        if (!(o1 && o2 && o3) || g1 !== ef || g2 !== ef || g3 !== ef) begin
            n_bad++;
            $display("FAIL retry frames: %b %b %b expected %b", g1, g2, g3, ef);
        end
        n_vec++;
        if ((inh_n - bi) !== 3) begin
            n_bad++;
            $display("FAIL retry inhibit_count: got %0d expected 3", inh_n - bi);
        end
        n_vec++;
        if (!wok || (done_n - bd) !== 1 || (err_n - be) !== 0 || err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL retry outcome: done %0d err %0d err_code %0d expected 1 0 0",
                     done_n - bd, err_n - be, err_code);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame(8'hED, "ed");
        test_frame(8'hF4, "f4");
        repeat (4) test_frame(8'($urandom), "rand");
`ifndef PS2_TX_RETRY_EN
        test_nack();
        test_nack();
        test_timeout();
`else
        test_retry();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
